piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends D[WIDTH-1] first, 0 sends D[0] first.
REQ-003 SHALL have port C  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port RE  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port D  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port LD  input  1  load request.
REQ-007 SHALL have port SO  output  1  serial data bit.
REQ-008 SHALL have port SV  output  1  serial valid; SO is meaningful only while SV=1.
REQ-009 SHALL have port BUSY  output  1  high while in SHIFT.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse after the last bit.

Function
REQ-011 SHALL implement states IDLE, SHIFT and DONE, with N = WIDTH serial bits per frame (WIDTH+1 under REQ-025).
REQ-012 IDLE: LD=1 at an edge SHALL load D into the shift register, clear the bit counter and move to SHIFT; LD=0 SHALL stay in IDLE.
REQ-013 SHIFT: every edge SHALL advance one bit and increment the counter; the edge with counter = N-1 SHALL move to DONE.
REQ-014 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-015 LD=1 at the edge leaving DONE SHALL load and move directly to SHIFT, giving back-to-back frames separated by one DONE cycle.
REQ-016 LD SHALL be ignored in SHIFT: no queuing and no corruption of the frame in flight.
REQ-017 SV SHALL be 1 exactly while in SHIFT, i.e. for N consecutive cycles beginning the cycle after the load edge.
REQ-018 SO SHALL be 0 whenever SV=0.
REQ-019 SO, SV, BUSY and DONE SHALL be decoded from registers only, with no combinational path from D or LD.
REQ-020 Latency SHALL be: first bit valid 1 cycle after the load edge; DONE high in cycle N+1 after the load edge.
REQ-021 The bit counter SHALL be $clog2(WIDTH+2) bits wide and SHALL never wrap within a frame.

Reset
REQ-022 RE=1 at an edge SHALL force state=IDLE, shift register=0, counter=0, SO=0, SV=0, BUSY=0, DONE=0.
REQ-023 RE SHALL take priority over LD at the same edge.
REQ-024 RE asserted mid-SHIFT SHALL abandon the frame, with no DONE pulse and no further valid bits.

Configuration
REQ-025 With PISO_PARITY_EN defined, N SHALL be WIDTH+1, and the final bit SHALL be even parity (XOR of the loaded word), sent with SV=1.
REQ-026 Without PISO_PARITY_EN, N SHALL be WIDTH, and no parity logic SHALL be synthesized.

Structure
REQ-027 A shared package piso_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the WIDTH default constant.
REQ-028 The shift register SHALL be built from WIDTH instances of sub-module d_ff_sync_re: a rising-edge D flip-flop with synchronous active-high reset and a load/shift data mux in front.

Verification
REQ-029 Reset: hold RE=1 for 2 cycles with LD=1 -> SO=0, SV=0, BUSY=0, DONE=0 throughout and after release.
REQ-030 MSB_FIRST=1, load 8'hA5 -> SO = 1,0,1,0,0,1,0,1 over 8 SV cycles, then DONE=1 for one cycle, then IDLE.
REQ-031 Pulse LD with D=8'hFF during bit 3 of an 8'h0F frame -> stream stays 0,0,0,0,1,1,1,1 and DONE pulses once.
REQ-032 Hold LD=1 with 8'h81 then 8'h7E -> two 8-bit frames with exactly one DONE cycle (SV=0) between them.
REQ-033 Assert RE after 3 bits of 8'hC3 -> SV=0 and SO=0 from the next cycle, no DONE, and the next LD starts a clean frame.
REQ-034 PISO_PARITY_EN, MSB_FIRST=0, load 8'h07 -> SO = 1,1,1,0,0,0,0,0 then parity 1, giving SV for 9 cycles with DONE in cycle 10.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: frame FSM states and default word width.
package piso_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/d_ff_sync_re.sv
// One shift-register stage: rising-edge flop with synchronous active-high reset,
// preceded by a load/shift mux (load wins over shift, otherwise the bit holds).
module d_ff_sync_re
    import piso_pkg::*;
(
    input  logic clk_i,
    input  logic re_i,
    input  logic load_i,
    input  logic shift_i,
    input  logic loadData_i,
    input  logic shiftData_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = loadData_i;
        end else if (shift_i) begin
            q_d = shiftData_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with IDLE/SHIFT/DONE framing.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             C,
    input  logic             RE,
    input  logic [WIDTH-1:0] D,
    input  logic             LD,
    output logic             SO,
    output logic             SV,
    output logic             BUSY,
    output logic             DONE
);

`ifdef PISO_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            load;
    logic            shift;
    logic [WIDTH-1:0] shiftReg_q;
    logic [WIDTH-1:0] shiftIn;
    logic            serialBit;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (LD) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift   = 1'b1;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (LD) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (RE) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Zeros are fed in at the far end so the register drains to 0 as bits leave.
    if (MSB_FIRST) begin : g_msb
        assign shiftIn = {shiftReg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
        assign shiftIn = {1'b0, shiftReg_q[WIDTH-1:1]};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_ff_sync_re u_ff (
            .clk_i       (C),
            .re_i        (RE),
            .load_i      (load),
            .shift_i     (shift),
            .loadData_i  (D[i]),
            .shiftData_i (shiftIn[i]),
            .q_o         (shiftReg_q[i])
        );
    end

    assign serialBit = MSB_FIRST ? shiftReg_q[WIDTH-1] : shiftReg_q[0];
    assign BUSY      = (state_q == ST_SHIFT);
    assign SV        = BUSY;
    assign DONE      = (state_q == ST_DONE);

`ifdef PISO_PARITY_EN
    logic parity_q;

    // Parity is captured at load time since the word is consumed while shifting.
    always_ff @(posedge C) begin
        if (RE) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^D;
        end
    end

    assign SO = BUSY & ((count_q == CW'(WIDTH)) ? parity_q : serialBit);
`else
    assign SO = BUSY & serialBit;
`endif

endmodule
